// File: rtl/ca_run_ctrl_if.sv
// Generation stream from the CA run controller.
// Master drives valid/data/index, slave drives ready.
interface ca_run_ctrl_if #(
   parameter int WIDTH = 32,
   parameter int GEN_W = 16
);
   logic             gen_valid;
   logic             gen_ready;
   logic [WIDTH-1:0] gen_data;
   logic [GEN_W-1:0] gen_index;

   modport master (
      output gen_valid,
      output gen_data,
      output gen_index,
      input  gen_ready
   );

   modport slave (
      input  gen_valid,
      input  gen_data,
      input  gen_index,
      output gen_ready
   );
endinterface

// File: rtl/ca_run_ctrl.sv
// Run controller for an external 1-D cellular-automaton array.
// Optional macro CA_FIXPOINT_EN: stop early on a fixed point.
module ca_run_ctrl #(
   parameter int WIDTH = 32,
   parameter int GEN_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [WIDTH-1:0]   seed,
   input  logic [7:0]         rule_in,
   input  logic [GEN_W-1:0]   gens,
   input  logic [1:0]         bmode,
   output logic               busy,
   output logic               done,
   ca_run_ctrl_if.master      gen,
   output logic               fixpoint,
   output logic [7:0]         ca_rule,
   output logic               ca_left,
   output logic               ca_right,
   output logic [WIDTH-1:0]   ca_state,
   output logic               ca_set_state,
   input  logic [WIDTH-1:0]   ca_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   seed_q;
   logic [7:0]         rule_q;
   logic [GEN_W-1:0]   gens_q;
   logic [1:0]         bmode_q;
   logic [GEN_W-1:0]   idx_q, idx_d;
   logic               latch;
   logic               fix_hit;
   logic               valid;

   // State, run parameters and generation index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         seed_q  <= '0;
         rule_q  <= '0;
         gens_q  <= '0;
         bmode_q <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (latch) begin
            seed_q  <= seed;
            rule_q  <= rule_in;
            gens_q  <= gens;
            bmode_q <= bmode;
         end
      end
   end

   // Next state and array control; default is to hold the array.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      latch        = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      valid        = 1'b0;
      ca_set_state = 1'b1;
      ca_state     = ca_out;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               latch   = 1'b1;
               idx_d   = '0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            busy = 1'b1;
            if (abort) begin
               state_d = IDLE;
            end else begin
               ca_state = seed_q;
               state_d  = RUN;
            end
         end
         RUN: begin
            busy  = 1'b1;
            valid = 1'b1;
            if (abort) begin
               state_d = IDLE;
            end else if (gen.gen_ready) begin
               if (idx_q == gens_q || fix_hit) begin
                  state_d = DONE;
               end else begin
                  ca_set_state = 1'b0;
                  idx_d        = idx_q + 1'b1;
               end
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // In reset the array is cleared rather than held.
      if (!rst_n) begin
         ca_state = '0;
      end
   end

`ifdef CA_FIXPOINT_EN
   logic [WIDTH-1:0] prev_q;
   logic             fix_q;
   logic             accept;

   assign accept  = (state_q == RUN) && gen.gen_ready && !abort;
   assign fix_hit = (idx_q != '0) && (ca_out == prev_q);

   // Previous accepted generation and sticky fixed-point flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= '0;
         fix_q  <= 1'b0;
      end else begin
         if (accept) begin
            prev_q <= ca_out;
         end
         if (latch) begin
            fix_q <= 1'b0;
         end else if (accept && fix_hit) begin
            fix_q <= 1'b1;
         end
      end
   end

   assign fixpoint = fix_q;
`else
   assign fix_hit  = 1'b0;
   assign fixpoint = 1'b0;
`endif

   // Boundary cells from the latched mode and the live array output.
   always_comb begin
      ca_left  = 1'b0;
      ca_right = 1'b0;
      unique case (bmode_q)
         2'd0: begin
            ca_left  = 1'b0;
            ca_right = 1'b0;
         end
         2'd1: begin
            ca_left  = 1'b1;
            ca_right = 1'b1;
         end
         2'd2: begin
            ca_left  = ca_out[WIDTH-1];
            ca_right = ca_out[0];
         end
         2'd3: begin
            ca_left  = ca_out[0];
            ca_right = ca_out[WIDTH-1];
         end
         default: begin
            ca_left  = 1'b0;
            ca_right = 1'b0;
         end
      endcase
   end

   assign ca_rule       = rule_q;
   assign gen.gen_valid = valid;
   assign gen.gen_data  = ca_out;
   assign gen.gen_index = idx_q;

endmodule

// File: tb/tb_ca_run_ctrl.sv
// Bench for ca_run_ctrl with an 8-cell CA array model.
// Expectations for the fixed-point vector follow CA_FIXPOINT_EN.
module tb_ca_run_ctrl;

   localparam int W = 8;
   localparam int G = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, abort;
   logic [W-1:0]  seed;
   logic [7:0]    rule_in;
   logic [G-1:0]  gens;
   logic [1:0]    bmode;
   logic          busy, done, fixpoint;
   logic [7:0]    ca_rule;
   logic          ca_left, ca_right, ca_set_state;
   logic [W-1:0]  ca_state;
   logic [W-1:0]  ca_out;
   logic [W-1:0]  ca_nxt;

   ca_run_ctrl_if #(.WIDTH(W), .GEN_W(G)) gif ();

   ca_run_ctrl #(.WIDTH(W), .GEN_W(G)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .seed         (seed),
      .rule_in      (rule_in),
      .gens         (gens),
      .bmode        (bmode),
      .busy         (busy),
      .done         (done),
      .gen          (gif),
      .fixpoint     (fixpoint),
      .ca_rule      (ca_rule),
      .ca_left      (ca_left),
      .ca_right     (ca_right),
      .ca_state     (ca_state),
      .ca_set_state (ca_set_state),
      .ca_out       (ca_out)
   );

   always #5 clk = ~clk;

   // CA array model: bit 0 is the leftmost cell.
   always_comb begin
      ca_nxt = '0;
      for (int i = 0; i < W; i++) begin
         logic l, s, r;
         l = (i == 0) ? ca_left : ca_out[(i + W - 1) % W];
         s = ca_out[i];
         r = (i == W - 1) ? ca_right : ca_out[(i + 1) % W];
         ca_nxt[i] = ca_rule[{l, s, r}];
      end
   end

   always_ff @(posedge clk) begin
      if (ca_set_state) ca_out <= ca_state;
      else              ca_out <= ca_nxt;
   end

   int n_cmp = 0;
   int n_bad = 0;
   logic [W-1:0] bd[$];
   logic [G-1:0] bi[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic run(input logic [7:0] s, input logic [7:0] r,
                      input logic [1:0] bm, input logic [15:0] g,
                      output int nb, output logic [7:0] last,
                      output bit sd);
      @(negedge clk);
      seed = s; rule_in = r; bmode = bm; gens = g;
      start = 1'b1; gif.gen_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("load_valid", {31'd0, gif.gen_valid}, 32'd0);
      nb = 0; sd = 1'b0; last = '0;
      bd.delete(); bi.delete();
      for (int c = 0; c < 400 && !sd; c++) begin
         if (gif.gen_valid && gif.gen_ready) begin
            bd.push_back(gif.gen_data);
            bi.push_back(gif.gen_index);
            nb++;
            last = gif.gen_data;
         end
         if (done) sd = 1'b1;
         else @(negedge clk);
      end
   endtask

   task automatic wait_idx(input logic [15:0] k, input string nm);
      int c;
      c = 0;
      while (!(gif.gen_valid && gif.gen_index == k) && c < 300) begin
         @(negedge clk);
         c++;
      end
      chk(nm, {16'd0, gif.gen_index}, {16'd0, k});
   endtask

   typedef struct {
      logic [7:0]  seed;
      logic [7:0]  rule;
      logic [1:0]  bm;
      logic [15:0] gens;
      int          nb;
      logic [7:0]  last;
      logic        fix;
   } vec_t;

   vec_t vt[6];

   initial begin
      int nb;
      logic [7:0] last;
      bit sd;
      logic [7:0] v;

`ifdef CA_FIXPOINT_EN
      vt[5] = '{8'h5A, 8'd204, 2'd0, 16'd10, 2, 8'h5A, 1'b1};
`else
      vt[5] = '{8'h5A, 8'd204, 2'd0, 16'd10, 11, 8'h5A, 1'b0};
`endif
      vt[0] = '{8'h01, 8'd90, 2'd2, 16'd1, 2, 8'h82, 1'b0};
      vt[1] = '{8'h01, 8'd90, 2'd0, 16'd1, 2, 8'h02, 1'b0};
      vt[2] = '{8'h00, 8'hFE, 2'd1, 16'd1, 2, 8'h81, 1'b0};
      vt[3] = '{8'h01, 8'd90, 2'd3, 16'd1, 2, 8'h03, 1'b0};
      vt[4] = '{8'hA5, 8'd90, 2'd0, 16'd0, 1, 8'hA5, 1'b0};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      seed = '0; rule_in = '0; gens = '0; bmode = '0;
      gif.gen_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_valid", {31'd0, gif.gen_valid}, 32'd0);
      chk("rst_index", {16'd0, gif.gen_index}, 32'd0);
      chk("rst_fix", {31'd0, fixpoint}, 32'd0);
      chk("rst_rule", {24'd0, ca_rule}, 32'd0);
      chk("rst_set", {31'd0, ca_set_state}, 32'd1);
      chk("rst_state", {24'd0, ca_state}, 32'd0);
      chk("rst_caout", {24'd0, ca_out}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic rule-90 run.
      run(8'h10, 8'd90, 2'd0, 16'd2, nb, last, sd);
      chk("t1_nbeats", nb, 3);
      chk("t1_done", {31'd0, sd}, 32'd1);
      if (nb == 3) begin
         chk("t1_d0", {24'd0, bd[0]}, 32'h10);
         chk("t1_d1", {24'd0, bd[1]}, 32'h28);
         chk("t1_d2", {24'd0, bd[2]}, 32'h44);
         chk("t1_i0", {16'd0, bi[0]}, 32'd0);
         chk("t1_i1", {16'd0, bi[1]}, 32'd1);
         chk("t1_i2", {16'd0, bi[2]}, 32'd2);
      end
      chk("t1_busy_done", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("t1_done_pulse", {31'd0, done}, 32'd0);
      repeat (3) @(negedge clk);
      chk("t1_idle_hold", {24'd0, ca_out}, 32'h44);

      // Boundary modes, gens=0 and fixed-point vectors.
      for (int k = 0; k < 6; k++) begin
         run(vt[k].seed, vt[k].rule, vt[k].bm, vt[k].gens, nb, last, sd);
         chk($sformatf("v%0d_nbeats", k), nb, vt[k].nb);
         chk($sformatf("v%0d_last", k), {24'd0, last},
             {24'd0, vt[k].last});
         chk($sformatf("v%0d_done", k), {31'd0, sd}, 32'd1);
         chk($sformatf("v%0d_fix", k), {31'd0, fixpoint},
             {31'd0, vt[k].fix});
      end

      // Backpressure at index 1.
      @(negedge clk);
      seed = 8'h10; rule_in = 8'd90; bmode = 2'd0; gens = 16'd2;
      start = 1'b1; gif.gen_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idx(16'd1, "bp_reach1");
      gif.gen_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("bp_data", {24'd0, gif.gen_data}, 32'h28);
         chk("bp_index", {16'd0, gif.gen_index}, 32'd1);
         chk("bp_valid", {31'd0, gif.gen_valid}, 32'd1);
      end
      gif.gen_ready = 1'b1;
      @(negedge clk);
      chk("bp_next_data", {24'd0, gif.gen_data}, 32'h44);
      chk("bp_next_index", {16'd0, gif.gen_index}, 32'd2);
      @(negedge clk);
      chk("bp_done", {31'd0, done}, 32'd1);

      // Abort at index 5 with an ignored start mid-run.
      @(negedge clk);
      seed = 8'h10; rule_in = 8'd90; bmode = 2'd0; gens = 16'd100;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idx(16'd2, "ab_reach2");
      seed = 8'hFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ab_start_ign", {16'd0, gif.gen_index}, 32'd3);
      chk("ab_busy", {31'd0, busy}, 32'd1);
      wait_idx(16'd5, "ab_reach5");
      chk("ab_data5", {24'd0, gif.gen_data}, 32'h02);
      v = ca_out;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("ab_busy_off", {31'd0, busy}, 32'd0);
      chk("ab_valid_off", {31'd0, gif.gen_valid}, 32'd0);
      chk("ab_frozen", {24'd0, ca_out}, {24'd0, v});
      sd = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (done) sd = 1'b1;
         @(negedge clk);
      end
      chk("ab_no_done", {31'd0, sd}, 32'd0);
      chk("ab_frozen2", {24'd0, ca_out}, {24'd0, v});

      // Reset asserted mid-run.
      seed = 8'h10; gens = 16'd100;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idx(16'd3, "rr_reach3");
      rst_n = 1'b0;
      #1;
      chk("rr_valid", {31'd0, gif.gen_valid}, 32'd0);
      chk("rr_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("rr_caout", {24'd0, ca_out}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
